// File: rtl/contador_ad_fecha.sv
// rtl/contador_ad_fecha.sv - date register (day/month/year) with daily advance and keyboard field editing
//
// Holds the calendar date for the RTC set path. In RUN the date advances on
// day_tick. While the keyboard FSM shows the date-edit screen, PS/2 scan codes
// move between fields (left/right) and change the selected field (up/down).
// The day is clamped to the month length after any month or year change.
//
// Ports:
//   clk          clock
//   rst          synchronous active-high reset
//   estado[7:0]  keyboard FSM state
//   en[1:0]      mode select
//   Cambio[7:0]  last received scan code
//   got_data     one-cycle strobe, Cambio valid
//   day_tick     one-cycle strobe, advance the date by one day
//   Dia[4:0]     day, 1..31
//   Mes[3:0]     month, 1..12
//   Anio         year, 0..YEAR_MAX (2000 + Anio)
//   Campo[1:0]   field under edit: 0=day, 1=month, 2=year (0 in RUN)
//   editando     registered edit-window flag
//   fecha_lista  one-cycle commit pulse

module contador_ad_fecha #(
  parameter int         YEAR_W    = 7,
  parameter int         YEAR_MAX  = 99,
  parameter logic [1:0] MODE_SEL  = 2'd2,
  parameter logic [7:0] STATE_SEL = 8'h7D,
  parameter logic [7:0] K_UP      = 8'h73,
  parameter logic [7:0] K_DOWN    = 8'h72,
  parameter logic [7:0] K_LEFT    = 8'h6B,
  parameter logic [7:0] K_RIGHT   = 8'h74,
  parameter logic [7:0] K_ENTER   = 8'h5A
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        estado,
  input  logic [1:0]        en,
  input  logic [7:0]        Cambio,
  input  logic              got_data,
  input  logic              day_tick,
  output logic [4:0]        Dia,
  output logic [3:0]        Mes,
  output logic [YEAR_W-1:0] Anio,
  output logic [1:0]        Campo,
  output logic              editando,
  output logic              fecha_lista
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    EDIT_DIA  = 2'd1,
    EDIT_MES  = 2'd2,
    EDIT_ANIO = 2'd3
  } state_t;

  localparam logic [YEAR_W-1:0] YMAX = YEAR_W'(YEAR_MAX);

  // ---------------------------------------------------------------------------
  // Calendar helpers
  // ---------------------------------------------------------------------------

  // Month length; leap years are the multiples of 4 within 2000..2099.
  function automatic logic [4:0] month_len(input logic [3:0] mes,
                                           input logic [YEAR_W-1:0] anio);
    logic [4:0] len;
    case (mes)
      4'd4, 4'd6, 4'd9, 4'd11: len = 5'd30;
      4'd2:                    len = (anio[1:0] == 2'b00) ? 5'd29 : 5'd28;
      default:                 len = 5'd31;
    endcase
    return len;
  endfunction

  function automatic logic [3:0] mes_inc(input logic [3:0] mes);
    return (mes >= 4'd12) ? 4'd1 : mes + 4'd1;
  endfunction

  function automatic logic [3:0] mes_dec(input logic [3:0] mes);
    return (mes <= 4'd1) ? 4'd12 : mes - 4'd1;
  endfunction

  function automatic logic [YEAR_W-1:0] anio_inc(input logic [YEAR_W-1:0] anio);
    return (anio >= YMAX) ? '0 : anio + YEAR_W'(1);
  endfunction

  function automatic logic [YEAR_W-1:0] anio_dec(input logic [YEAR_W-1:0] anio);
    return (anio == '0) ? YMAX : anio - YEAR_W'(1);
  endfunction

  // Keeps the day inside the (possibly new) month length.
  function automatic logic [4:0] clamp_dia(input logic [4:0] dia,
                                           input logic [4:0] max_d);
    return (dia > max_d) ? max_d : dia;
  endfunction

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t            state_q, state_d;
  logic [4:0]        dia_q, dia_d;
  logic [3:0]        mes_q, mes_d;
  logic [YEAR_W-1:0] anio_q, anio_d;
  logic              editando_q, editando_d;
  logic              fecha_lista_q, fecha_lista_d;

  // ---------------------------------------------------------------------------
  // Input decode
  // ---------------------------------------------------------------------------
  logic       edit;
  logic       edit_rise;
  logic       key_up, key_down, key_left, key_right, key_enter;
  logic [4:0] max_dia;

  always_comb begin
    edit      = (en == MODE_SEL) && (estado == STATE_SEL);
    // editando_q is the previous-cycle copy of edit, so it doubles as the edge detector.
    edit_rise = edit && !editando_q;
    key_up    = got_data && (Cambio == K_UP);
    key_down  = got_data && (Cambio == K_DOWN);
    key_left  = got_data && (Cambio == K_LEFT);
    key_right = got_data && (Cambio == K_RIGHT);
    key_enter = got_data && (Cambio == K_ENTER);
    max_dia   = month_len(mes_q, anio_q);
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        // Keys on the same edge as the rise are dropped because RUN ignores them.
        if (edit_rise) state_d = EDIT_DIA;
      end
      EDIT_DIA: begin
        if (!edit)          state_d = RUN;
        else if (key_enter) state_d = EDIT_DIA;
        else if (key_right) state_d = EDIT_MES;
        else if (key_left)  state_d = EDIT_ANIO;
      end
      EDIT_MES: begin
        if (!edit)          state_d = RUN;
        else if (key_enter) state_d = EDIT_DIA;
        else if (key_right) state_d = EDIT_ANIO;
        else if (key_left)  state_d = EDIT_DIA;
      end
      EDIT_ANIO: begin
        if (!edit)          state_d = RUN;
        else if (key_enter) state_d = EDIT_DIA;
        else if (key_right) state_d = EDIT_DIA;
        else if (key_left)  state_d = EDIT_MES;
      end
      default: state_d = RUN;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    Campo = 2'd0;
    case (state_q)
      EDIT_MES:  Campo = 2'd1;
      EDIT_ANIO: Campo = 2'd2;
      default:   Campo = 2'd0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Date datapath and commit pulse
  // ---------------------------------------------------------------------------
  always_comb begin
    dia_d         = dia_q;
    mes_d         = mes_q;
    anio_d        = anio_q;
    editando_d    = edit;
    fecha_lista_d = 1'b0;

    if (state_q == RUN) begin
      if (day_tick) begin
        if (dia_q < max_dia) begin
          dia_d = dia_q + 5'd1;
        end else begin
          // Day restarts at 1, which is legal in every month: no clamp needed.
          dia_d = 5'd1;
          mes_d = mes_inc(mes_q);
          if (mes_q >= 4'd12) anio_d = anio_inc(anio_q);
        end
      end
    end else if (!edit) begin
      // Leaving the edit screen commits the date.
      fecha_lista_d = 1'b1;
    end else if (key_enter) begin
      fecha_lista_d = 1'b1;
    end else if (key_up || key_down) begin
      case (state_q)
        EDIT_DIA: begin
          if (key_up) dia_d = (dia_q >= max_dia) ? 5'd1 : dia_q + 5'd1;
          else        dia_d = (dia_q <= 5'd1) ? max_dia : dia_q - 5'd1;
        end
        EDIT_MES: begin
          mes_d = key_up ? mes_inc(mes_q) : mes_dec(mes_q);
          dia_d = clamp_dia(dia_q, month_len(mes_d, anio_q));
        end
        EDIT_ANIO: begin
          anio_d = key_up ? anio_inc(anio_q) : anio_dec(anio_q);
          dia_d  = clamp_dia(dia_q, month_len(mes_q, anio_d));
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dia_q         <= 5'd1;
      mes_q         <= 4'd1;
      anio_q        <= '0;
      editando_q    <= 1'b0;
      fecha_lista_q <= 1'b0;
    end else begin
      dia_q         <= dia_d;
      mes_q         <= mes_d;
      anio_q        <= anio_d;
      editando_q    <= editando_d;
      fecha_lista_q <= fecha_lista_d;
    end
  end

  assign Dia         = dia_q;
  assign Mes         = mes_q;
  assign Anio        = anio_q;
  assign editando    = editando_q;
  assign fecha_lista = fecha_lista_q;

endmodule

// File: tb/tb_contador_ad_fecha.sv
// tb/tb_contador_ad_fecha.sv - directed self-checking bench for contador_ad_fecha

module tb_contador_ad_fecha;

  localparam int YEAR_W = 7;

  localparam logic [7:0] K_UP    = 8'h73;
  localparam logic [7:0] K_DOWN  = 8'h72;
  localparam logic [7:0] K_LEFT  = 8'h6B;
  localparam logic [7:0] K_RIGHT = 8'h74;
  localparam logic [7:0] K_ENTER = 8'h5A;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        estado;
  logic [1:0]        en;
  logic [7:0]        Cambio;
  logic              got_data;
  logic              day_tick;
  logic [4:0]        Dia;
  logic [3:0]        Mes;
  logic [YEAR_W-1:0] Anio;
  logic [1:0]        Campo;
  logic              editando;
  logic              fecha_lista;

  int vectors    = 0;
  int miscompares = 0;

  contador_ad_fecha dut (
    .clk         (clk),
    .rst         (rst),
    .estado      (estado),
    .en          (en),
    .Cambio      (Cambio),
    .got_data    (got_data),
    .day_tick    (day_tick),
    .Dia         (Dia),
    .Mes         (Mes),
    .Anio        (Anio),
    .Campo       (Campo),
    .editando    (editando),
    .fecha_lista (fecha_lista)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
      else begin
        miscompares++;
        $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
  endtask

  task automatic check_date(input string tag, input int d, input int m, input int y);
    check({tag, ".dia"},  32'(Dia),  32'(d));
    check({tag, ".mes"},  32'(Mes),  32'(m));
    check({tag, ".anio"}, 32'(Anio), 32'(y));
  endtask

  // One clock edge; inputs change 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Consecutive calls keep got_data high across edges, giving back-to-back strobes.
  task automatic press(input logic [7:0] code);
    Cambio   = code;
    got_data = 1'b1;
    step();
    got_data = 1'b0;
  endtask

  task automatic press_n(input logic [7:0] code, input int n);
    for (int i = 0; i < n; i++) press(code);
  endtask

  task automatic tick();
    day_tick = 1'b1;
    step();
    day_tick = 1'b0;
  endtask

  initial begin
    rst = 1'b1; estado = 8'h00; en = 2'd0; Cambio = 8'h00; got_data = 1'b0; day_tick = 1'b0;
    step();
    step();
    rst = 1'b0;

    // Reset values
    check_date("reset", 1, 1, 0);
    check("reset.campo",       32'(Campo),       0);
    check("reset.editando",    32'(editando),    0);
    check("reset.fecha_lista", 32'(fecha_lista), 0);

    // Keys in RUN are ignored
    press_n(K_UP, 3);
    step();
    check_date("run_keys", 1, 1, 0);

    // Wrong estado keeps the edit window closed
    en = 2'd2; estado = 8'h7C;
    step();
    press_n(K_UP, 3);
    check("gate.editando", 32'(editando), 0);
    check_date("gate", 1, 1, 0);

    // Open edit window
    estado = 8'h7D;
    step();
    check("edit.editando", 32'(editando), 1);
    check("edit.campo",    32'(Campo),    0);

    // Build 28/02/24: year first, then month, then day
    press_n(K_RIGHT, 2);
    check("nav.campo_anio", 32'(Campo), 2);
    press_n(K_UP, 24);
    press(K_LEFT);
    check("nav.campo_mes", 32'(Campo), 1);
    press(K_UP);
    press(K_LEFT);
    press_n(K_UP, 27);
    check_date("set_28_2_24", 28, 2, 24);

    // Leap February: 28 -> 29 -> 1
    press(K_UP);
    check("leap.up29", 32'(Dia), 29);
    press(K_UP);
    check("leap.wrap1", 32'(Dia), 1);

    // Year 25, day 1 down -> 28
    press_n(K_RIGHT, 2);
    press(K_UP);
    check("y25.anio", 32'(Anio), 25);
    press_n(K_LEFT, 2);
    check("y25.campo", 32'(Campo), 0);
    press(K_DOWN);
    check_date("nonleap_down", 28, 2, 25);

    // 31/01/25 then month up clamps day to 28
    press(K_RIGHT);
    press(K_DOWN);
    press(K_LEFT);
    press_n(K_UP, 3);
    check_date("set_31_1_25", 31, 1, 25);
    press(K_RIGHT);
    press(K_UP);
    check_date("mes_clamp", 28, 2, 25);

    // 29/02/24 then year up clamps day to 28
    press(K_RIGHT);
    press(K_DOWN);
    press(K_RIGHT);
    check("wrap_right.campo", 32'(Campo), 0);
    press(K_UP);
    check_date("set_29_2_24", 29, 2, 24);
    press(K_LEFT);
    check("wrap_left.campo", 32'(Campo), 2);
    press(K_UP);
    check_date("anio_clamp", 28, 2, 25);

    // day_tick during edit is ignored
    tick();
    step();
    check_date("edit_tick", 28, 2, 25);

    // ENTER: one-cycle commit pulse and back to day field
    press(K_ENTER);
    check("enter.pulse", 32'(fecha_lista), 1);
    check("enter.campo", 32'(Campo),       0);
    step();
    check("enter.pulse_end", 32'(fecha_lista), 0);
    check("enter.editando",  32'(editando),    1);

    // Build 31/12/99: year 25 down 26 times wraps through 0 to 99
    press(K_LEFT);
    press_n(K_DOWN, 26);
    press(K_LEFT);
    press_n(K_DOWN, 2);
    press(K_LEFT);
    press_n(K_UP, 3);
    check_date("set_31_12_99", 31, 12, 99);

    // Leaving the edit window commits
    estado = 8'h00;
    step();
    check("exit.pulse",    32'(fecha_lista), 1);
    check("exit.editando", 32'(editando),    0);
    check("exit.campo",    32'(Campo),       0);
    step();
    check("exit.pulse_end", 32'(fecha_lista), 0);

    // Year rollover on tick
    tick();
    check_date("tick_rollover", 1, 1, 0);

    // Build 30/04/00 and tick into May
    estado = 8'h7D;
    step();
    press(K_RIGHT);
    press_n(K_UP, 3);
    press(K_LEFT);
    press_n(K_UP, 29);
    check_date("set_30_4_0", 30, 4, 0);
    estado = 8'h00;
    step();
    step();
    tick();
    check_date("tick_month", 1, 5, 0);
    tick();
    check_date("tick_plain", 2, 5, 0);

    // Reset mid-edit at year field: no commit pulse
    estado = 8'h7D;
    step();
    press_n(K_RIGHT, 2);
    check("rst_edit.campo", 32'(Campo), 2);
    press(K_UP);
    rst = 1'b1;
    step();
    check_date("rst_edit", 1, 1, 0);
    check("rst_edit.campo_r",    32'(Campo),       0);
    check("rst_edit.editando",   32'(editando),    0);
    check("rst_edit.pulse",      32'(fecha_lista), 0);
    estado = 8'h00;
    step();
    rst = 1'b0;
    step();
    check("rst_edit.pulse_after", 32'(fecha_lista), 0);
    check_date("rst_edit_after", 1, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/contador_ad_fecha.md
# contador_ad_fecha

Parametrised date register for the real-time clock set path. It holds day, month and year, and runs the date forward on a daily tick from the timekeeping chain. While the keyboard FSM selects the date-edit screen, PS/2 scan codes adjust the date field by field: left/right select the field, up/down change its value. Day limits follow the month length and leap years, and the day is clamped automatically after any month or year change. Outputs feed the display multiplexer and the RTC write-back logic.

## Interface
- `YEAR_W`, 7: year field width.
- `YEAR_MAX`, 99: last year value; the year wraps to 0 after it (years 2000+year).
- `MODE_SEL`, 2'd2: `en` value that enables editing.
- `STATE_SEL`, 8'h7D: `estado` value that enables editing.
- `K_UP`, 8'h73: increment scan code.
- `K_DOWN`, 8'h72: decrement scan code.
- `K_LEFT`, 8'h6B: previous-field scan code.
- `K_RIGHT`, 8'h74: next-field scan code.
- `K_ENTER`, 8'h5A: commit scan code.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `estado` in 8: keyboard FSM state.
- `en` in 2: mode select.
- `Cambio` in 8: last received scan code.
- `got_data` in 1: one-cycle strobe, `Cambio` valid.
- `day_tick` in 1: one-cycle strobe, advance the date by one day.
- `Dia` out 5: day, 1..31.
- `Mes` out 4: month, 1..12.
- `Anio` out YEAR_W: year, 0..YEAR_MAX.
- `Campo` out 2: field under edit: 0=day, 1=month, 2=year.
- `editando` out 1: edit window active (registered).
- `fecha_lista` out 1: one-cycle commit pulse.

## Operation
- Edit window: `edit = (en==MODE_SEL && estado==STATE_SEL)`. `editando` is the registered copy of `edit`.
- State machine: RUN, EDIT_DIA, EDIT_MES, EDIT_ANIO.
  - RUN -> EDIT_DIA when `edit` rises.
  - Any EDIT state -> RUN when `edit` falls. Leaving this way also pulses `fecha_lista`.
  - `Campo` mirrors the current EDIT state and is 0 in RUN.
- Month length `max_dia`:
  - 31 for months 1,3,5,7,8,10,12.
  - 30 for months 4,6,9,11.
  - February: 29 when `Anio[1:0]==0`, else 28.
- RUN: on `day_tick`:
  - If `Dia<max_dia`, increment `Dia`.
  - Otherwise `Dia=1` and the month advances; month 12 -> 1 with a year carry.
  - Year `YEAR_MAX` -> 0.
  - Key strobes are ignored in RUN.
- EDIT states: `got_data` is acted on only when `Cambio` matches a key parameter. Any other code is ignored.
  - `K_RIGHT`: DIA->MES->ANIO->DIA.
  - `K_LEFT`: the reverse order.
  - `K_UP` on the day: `max_dia` wraps to 1. On the month: 12 wraps to 1. On the year: `YEAR_MAX` wraps to 0.
  - `K_DOWN` on the day: 1 wraps to `max_dia`. On the month: 1 wraps to 12. On the year: 0 wraps to `YEAR_MAX`.
  - `K_ENTER`: pulse `fecha_lista`, return to EDIT_DIA, no value change.
- Clamp: when the month or year changes (edit or tick carry), if `Dia` exceeds the new `max_dia`, `Dia` takes that `max_dia` in the same update.
- `day_tick` during EDIT is ignored and not queued.
- Arithmetic: all updates are computed combinationally from current register values and written in one edge. No value outside its legal range is ever registered.
- Reset (overrides everything):
  - `Dia=1`, `Mes=1`, `Anio=0`.
  - `Campo=0`, `editando=0`, `fecha_lista=0`.
  - State RUN.
  - Reset mid-edit discards the edit without a `fecha_lista` pulse.

## Timing
- Key and tick latency is 1 cycle: outputs update on the edge that samples the strobe.
- `editando` and the state change on the edge after `edit` changes. A key arriving on the same edge as `edit` rising is ignored.
- `fecha_lista` is high for exactly 1 cycle, on the edge after ENTER or after `edit` falls.
- Back-to-back `got_data` strobes on consecutive cycles are each processed.

## Test plan
- Reset -> `Dia=1`, `Mes=1`, `Anio=0`, `Campo=0`, `editando=0`, `fecha_lista=0`; 3 `K_UP` presses in RUN leave the value unchanged.
- Edit with `Anio=24`, `Mes=2`, `Dia=28`: `K_UP` -> 29, `K_UP` -> 1; set `Anio=25`, `K_DOWN` from day 1 -> 28.
- `Dia=31`, `Mes=1`, `Anio=25`: `K_RIGHT`, `K_UP` -> `Mes=2`, `Dia=28`; `Dia=29`, `Mes=2`, `Anio=24`, year `K_UP` -> `Anio=25`, `Dia=28`.
- RUN with 31/12/`YEAR_MAX`, one `day_tick` -> 1/1/0; 30/4/x, one `day_tick` -> 1/5/x.
- Edit gating: `estado=8'h7C` with `K_UP` strobes -> no change; `K_ENTER` in edit -> `fecha_lista` 1-cycle pulse and `Campo=0`.
- `rst` asserted mid-edit at `Campo=2` -> reset values, no `fecha_lista` pulse; `day_tick` during edit -> date unchanged.
